// File: rtl/instr_loader.sv
// instr_loader: loads a length-prefixed byte stream into instruction RAM and holds the core in reset until done.
// Define INSTR_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the data.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [15:0] pc,
  output logic [31:0] instr,
  output logic        cpu_reset,
  output logic [15:0] loaded_words,
  output logic        error
);
  localparam logic [2:0] LEN_HI = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] CHK    = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
  logic [2:0]  state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [31:0] mem [0:(1 << ADDR_W) - 1];
  logic        xfer;
  logic        word_done;
  logic        in_range;
  logic        last_word;
  logic        err_next;
  logic [2:0]  data_done;
  logic [2:0]  empty_done;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  assign data_done  = CHK;
  assign empty_done = CHK;
`else
  assign data_done  = err_next ? ERROR : RUN;
  assign empty_done = RUN;
`endif
  assign rx_ready     = state != RUN && state != ERROR;
  assign xfer         = rx_valid && rx_ready;
  assign word_done    = xfer && state == DATA && byte_idx == 2'd3;
  assign in_range     = {1'b0, word_idx} < DEPTH;
  assign last_word    = word_idx == n_words - 16'd1;
  assign err_next     = error || (word_done && !in_range);
  assign loaded_words = word_idx;
  assign instr        = ({1'b0, pc} < DEPTH) ? mem[pc[ADDR_W-1:0]] : 32'h0;
  // reload behaves exactly like reset, and wins over any byte offered on the same edge
  always_ff @(posedge clk) begin
    if (!reset || reload) begin
      state     <= LEN_HI;
      cpu_reset <= 1'b1;
      error     <= 1'b0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      cpu_reset <= state != RUN;
      if (xfer) begin
        case (state)
          LEN_HI: begin
            n_words[15:8] <= rx_data;
            state         <= LEN_LO;
          end
          LEN_LO: begin
            n_words[7:0] <= rx_data;
            state        <= ({n_words[15:8], rx_data} == 16'd0) ? empty_done : DATA;
          end
          DATA: begin
            asm_q    <= {asm_q[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              word_idx <= word_idx + 16'd1;
              error    <= err_next;
              if (last_word) state <= data_done;
            end
          end
`ifdef INSTR_LOADER_CHECKSUM_EN
          CHK: begin
            if (rx_data != csum || error) begin
              error <= 1'b1;
              state <= ERROR;
            end else state <= RUN;
          end
`endif
          default: ;
        endcase
      end
    end
  end
  // words past the end of RAM are consumed but dropped so the stream stays aligned
  always_ff @(posedge clk)
    if (reset && !reload && word_done && in_range) mem[word_idx[ADDR_W-1:0]] <= {asm_q, rx_data};
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed checks of instr_loader at ADDR_W=8 and a 4-word instance for overflow.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        reload = 1'b0;
  logic [15:0] pc = 16'h0;
  logic        rx_ready, cpu_reset, error;
  logic [31:0] instr;
  logic [15:0] loaded_words;
  logic        s_rx_ready, s_cpu_reset, s_error;
  logic [31:0] s_instr;
  logic [15:0] s_loaded_words;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_loader u_dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .pc(pc), .instr(instr), .cpu_reset(cpu_reset),
    .loaded_words(loaded_words), .error(error)
  );

  instr_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(s_rx_ready),
    .reload(reload), .pc(pc), .instr(s_instr), .cpu_reset(s_cpu_reset),
    .loaded_words(s_loaded_words), .error(s_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    chk("rx_ready_on_send", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    pc = a;
    #1;
    chk(tag, instr, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_loaded", {16'd0, loaded_words}, 32'd0);
    chk("rst_ready", {31'd0, rx_ready}, 32'd1);

    // back-to-back two-word image
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    rd("w0_next_cycle", 16'h0000, 32'h12345678);
    send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("t1_loaded", {16'd0, loaded_words}, 32'd2);
    chk("t1_ready_run", {31'd0, rx_ready}, 32'd0);
    chk("t1_cpu_reset_hold", {31'd0, cpu_reset}, 32'd1);
    idle(1);
    chk("t1_cpu_reset_fall", {31'd0, cpu_reset}, 32'd0);
    chk("t1_error", {31'd0, error}, 32'd0);
    rd("t1_pc1", 16'h0001, 32'h9ABCDEF0);
    rd("t1_pc0", 16'h0000, 32'h12345678);
    rd("t1_pc_oob", 16'h0100, 32'h0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("run_ignores_bytes", {16'd0, loaded_words}, 32'd2);

    // reload, then the same shape of image with gaps between bytes
    do_reload();
    chk("rl_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rl_loaded", {16'd0, loaded_words}, 32'd0);
    chk("rl_ready", {31'd0, rx_ready}, 32'd1);
    send(8'h00); idle(1); send(8'h02); idle(1);
    send(8'hAA); idle(1); send(8'hBB); idle(1); send(8'hCC); idle(1); send(8'hDD); idle(1);
    send(8'h11); idle(1); send(8'h22); idle(1); send(8'h33); idle(1); send(8'h44);
`ifdef INSTR_LOADER_CHECKSUM_EN
    idle(1); send(8'h44);
`endif
    chk("t2_loaded", {16'd0, loaded_words}, 32'd2);
    chk("t2_cpu_reset_hold", {31'd0, cpu_reset}, 32'd1);
    idle(1);
    chk("t2_cpu_reset_fall", {31'd0, cpu_reset}, 32'd0);
    rd("t2_pc0", 16'h0000, 32'hAABBCCDD);
    rd("t2_pc1", 16'h0001, 32'h11223344);

    // N=5 into a 4-word RAM: fifth word dropped
    do_reset();
    send(8'h00); send(8'h05);
    for (int i = 1; i <= 20; i++) send(8'(i));
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h14);
`endif
    idle(1);
    chk("ovf_error", {31'd0, s_error}, 32'd1);
    chk("ovf_loaded", {16'd0, s_loaded_words}, 32'd5);
    chk("ovf_ready", {31'd0, s_rx_ready}, 32'd0);
    chk("ovf_cpu_reset", {31'd0, s_cpu_reset}, 32'd1);
    pc = 16'h0000; #1; chk("ovf_w0", s_instr, 32'h01020304);
    pc = 16'h0003; #1; chk("ovf_w3", s_instr, 32'h0D0E0F10);
    pc = 16'h0004; #1; chk("ovf_pc_oob", s_instr, 32'h0);
    chk("big_no_error", {31'd0, error}, 32'd0);
    rd("big_w4", 16'h0004, 32'h11121314);

    // empty image
    do_reset();
    send(8'h00); send(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("n0_ready", {31'd0, rx_ready}, 32'd0);
    chk("n0_loaded", {16'd0, loaded_words}, 32'd0);
    idle(1);
    chk("n0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    rd("n0_no_write", 16'h0000, 32'h01020304);

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_reset();
    send(8'h00); send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    chk("ck_ok_ready", {31'd0, rx_ready}, 32'd0);
    chk("ck_ok_error", {31'd0, error}, 32'd0);
    idle(1);
    chk("ck_ok_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    do_reset();
    send(8'h00); send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    idle(1);
    chk("ck_bad_error", {31'd0, error}, 32'd1);
    chk("ck_bad_ready", {31'd0, rx_ready}, 32'd0);
    chk("ck_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    do_reload();
    chk("ck_rl_error", {31'd0, error}, 32'd0);
    chk("ck_rl_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("ck_rl_ready", {31'd0, rx_ready}, 32'd1);
`endif

    // reload collides with the third data byte of word 0
    do_reset();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    rx_data = 8'hCC;
    rx_valid = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    reload = 1'b0;
    chk("mid_rl_loaded", {16'd0, loaded_words}, 32'd0);
    chk("mid_rl_ready", {31'd0, rx_ready}, 32'd1);
    rd("mid_rl_no_write", 16'h0000, 32'h01020304);
    send(8'h00); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h22);
`endif
    chk("mid_rl_reloaded", {16'd0, loaded_words}, 32'd1);
    rd("mid_rl_word", 16'h0000, 32'hDEADBEEF);
    idle(1);
    chk("mid_rl_run", {31'd0, cpu_reset}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
